// File: rtl/irq_controller.sv
// Edge-capturing, maskable, fixed-priority interrupt controller on the core data bus; a rising source edge reaches oInterrupt 2 edges later, register reads are combinational.
// Backpressure: none -- a request is held in REQ until kernel entry or withdrawal, and later sources wait in PEND.
module irq_controller #(
  parameter int          N_SRC     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h40000020
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] iSrc,
  input  logic             iKernelMode,
  input  logic [31:0]      iAddr,
  input  logic             iRead,
  input  logic             iWrite,
  input  logic [31:0]      iWriteData,
  output logic [31:0]      oReadData,
  output logic             oInterrupt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [N_SRC-1:0] srcD;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic             gen;
  logic             causeVld;
  logic [2:0]       causeId;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] w1cClr;
  logic [N_SRC-1:0] ackClr;
  logic             sel;
  logic [1:0]       regSel;
  logic             wrPend;
  logic             wrMask;
  logic             wrCtrl;
  logic [2:0]       winId;
  logic             latchedActive;
  logic             reqLatch;
  logic             reqAck;
  logic             reqWithdraw;
  logic             unusedBits;

  // Only word selection matters; byte offset and the upper write-data bits are don't-care.
  assign unusedBits = ^{iAddr[1:0], iWriteData};

  assign sel    = (iAddr[31:4] == BASE_ADDR[31:4]);
  assign regSel = iAddr[3:2];
  assign wrPend = sel && iWrite && (regSel == 2'd0);
  assign wrMask = sel && iWrite && (regSel == 2'd1);
  assign wrCtrl = sel && iWrite && (regSel == 2'd3);

  assign rise   = iSrc & ~srcD;
  assign active = pend & mask & {N_SRC{gen}};
  assign w1cClr = wrPend ? iWriteData[N_SRC-1:0] : '0;

  // Lowest set index wins: scan high to low so the last hit is the lowest.
  always_comb begin
    winId = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) winId = 3'(i);
    end
  end

  always_comb begin
    latchedActive = 1'b0;
    ackClr        = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (3'(i) == causeId) begin
        latchedActive = active[i];
        ackClr[i]     = reqAck;
      end
    end
  end

  always_comb begin
    stateNext   = state;
    reqLatch    = 1'b0;
    reqAck      = 1'b0;
    reqWithdraw = 1'b0;
    case (state)
      IDLE: begin
        if (gen && (|active) && !iKernelMode) begin
          stateNext = REQ;
          reqLatch  = 1'b1;
        end
      end
      REQ: begin
        // Kernel entry wins over a same-cycle withdrawal: the core already took the trap.
        if (iKernelMode) begin
          stateNext = SERVICE;
          reqAck    = 1'b1;
        end else if (!latchedActive) begin
          stateNext   = IDLE;
          reqWithdraw = 1'b1;
        end
      end
      SERVICE: begin
        if (!iKernelMode) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      srcD     <= '0;
      pend     <= '0;
      mask     <= '0;
      gen      <= 1'b0;
      causeVld <= 1'b0;
      causeId  <= 3'd0;
    end else begin
      srcD <= iSrc;
      // New edges are ORed in last so they survive a same-cycle W1C or acknowledge.
      pend <= (pend & ~w1cClr & ~ackClr) | rise;
      if (wrMask) mask <= iWriteData[N_SRC-1:0];
      if (wrCtrl) gen  <= iWriteData[0];
      if (reqLatch) begin
        causeVld <= 1'b1;
        causeId  <= winId;
      end else if (reqWithdraw) begin
        causeVld <= 1'b0;
      end
    end
  end

  always_comb begin
    oReadData = '0;
    if (sel && iRead) begin
      case (regSel)
        2'd0:    oReadData[N_SRC-1:0] = pend;
        2'd1:    oReadData[N_SRC-1:0] = mask;
        2'd2:    oReadData = {causeVld, 28'd0, causeId};
        default: oReadData[0] = gen;
      endcase
    end
  end

  assign oInterrupt = (state == REQ);

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

  localparam logic [31:0] BASE    = 32'h40000020;
  localparam logic [31:0] PEND_A  = BASE;
  localparam logic [31:0] MASK_A  = BASE + 32'd4;
  localparam logic [31:0] CAUSE_A = BASE + 32'd8;
  localparam logic [31:0] CTRL_A  = BASE + 32'd12;

  logic        clk;
  logic        reset;
  logic [3:0]  iSrc;
  logic        iKernelMode;
  logic [31:0] iAddr;
  logic        iRead;
  logic        iWrite;
  logic [31:0] iWriteData;
  logic [31:0] oReadData;
  logic        oInterrupt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ[$];

  irq_controller #(.N_SRC(4), .BASE_ADDR(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .iSrc(iSrc),
    .iKernelMode(iKernelMode),
    .iAddr(iAddr),
    .iRead(iRead),
    .iWrite(iWrite),
    .iWriteData(iWriteData),
    .oReadData(oReadData),
    .oInterrupt(oInterrupt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    iAddr      = a;
    iWriteData = d;
    iWrite     = 1'b1;
    tick();
    iWrite     = 1'b0;
    iAddr      = '0;
    iWriteData = '0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    iAddr = a;
    iRead = 1'b1;
    #1;
    d     = oReadData;
    iRead = 1'b0;
    iAddr = '0;
  endtask

  task automatic waitIrq(output int cyc, output bit timedOut);
    cyc = 0;
    while (oInterrupt !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    timedOut = (oInterrupt !== 1'b1);
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    reset = 1'b0;
    iSrc  = 4'hF;
    repeat (3) tick();
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL reset_irq got %b want 0", oInterrupt);
    end
    for (int i = 0; i < 4; i++) begin
      busRead(BASE + 32'(i * 4), rd);
      checks++;
      if (rd !== 32'd0) begin
        errors++; $display("FAIL reset_reg%0d got %h want 0", i, rd);
      end
    end
    reset = 1'b1;
    busRead(PEND_A, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL reset_release_pend got %h want 0", rd);
    end
    tick();
    busRead(PEND_A, rd);
    checks++;
    if (rd !== 32'hF) begin
      errors++; $display("FAIL reset_first_edge_pend got %h want f", rd);
    end
    iSrc = 4'h0;
    busWrite(PEND_A, 32'hF);
    busRead(PEND_A, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL reset_w1c_pend got %h want 0", rd);
    end
  endtask

  task automatic test_regs;
    logic [31:0] rd;
    busWrite(MASK_A, 32'hFFFF_FFFF);
    busRead(MASK_A, rd);
    checks++;
    if (rd !== 32'hF) begin
      errors++; $display("FAIL regs_mask got %h want f", rd);
    end
    busRead(MASK_A + 32'd3, rd);
    checks++;
    if (rd !== 32'hF) begin
      errors++; $display("FAIL regs_mask_bytelane got %h want f", rd);
    end
    busRead(BASE + 32'h14, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL regs_outside got %h want 0", rd);
    end
    busWrite(CTRL_A, 32'hFFFF_FFFF);
    busRead(CTRL_A, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++; $display("FAIL regs_ctrl got %h want 1", rd);
    end
    busWrite(CAUSE_A, 32'hFFFF_FFFF);
    busRead(CAUSE_A, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL regs_cause_ro got %h want 0", rd);
    end
    busWrite(CTRL_A, 32'd0);
    busWrite(MASK_A, 32'd0);
  endtask

  task automatic test_basic;
    logic [31:0] rd, exp;
    int cyc;
    bit to;
    busWrite(MASK_A, 32'h4);
    busWrite(CTRL_A, 32'h1);
    iSrc = 4'h4;
    expQ.push_back(32'h8000_0002);
    waitIrq(cyc, to);
    checks++;
    if (to || cyc != 2) begin
      errors++; $display("FAIL basic_latency got %0d timeout %0d want 2", cyc, to);
    end
    iSrc = 4'h0;
    busRead(CAUSE_A, rd);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++; $display("FAIL basic_cause got %h want %h", rd, exp);
    end
    iKernelMode = 1'b1;
    tick();
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL basic_ack_irq got %b want 0", oInterrupt);
    end
    busRead(PEND_A, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL basic_ack_pend got %h want 0", rd);
    end
    iKernelMode = 1'b0;
    tick();
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL basic_return_irq got %b want 0", oInterrupt);
    end
    busRead(CAUSE_A, rd);
    checks++;
    if (rd !== 32'h8000_0002) begin
      errors++; $display("FAIL basic_cause_kept got %h want 80000002", rd);
    end
  endtask

  task automatic test_priority;
    logic [31:0] rd, exp;
    int cyc;
    bit to;
    busWrite(MASK_A, 32'hF);
    iSrc = 4'hA;
    expQ.push_back(32'h8000_0001);
    expQ.push_back(32'h8000_0003);
    waitIrq(cyc, to);
    checks++;
    if (to || cyc != 2) begin
      errors++; $display("FAIL prio_latency got %0d timeout %0d want 2", cyc, to);
    end
    iSrc = 4'h0;
    busRead(CAUSE_A, rd);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++; $display("FAIL prio_cause1 got %h want %h", rd, exp);
    end
    iKernelMode = 1'b1;
    tick();
    busRead(PEND_A, rd);
    checks++;
    if (rd !== 32'h8) begin
      errors++; $display("FAIL prio_service_pend got %h want 8", rd);
    end
    repeat (2) tick();
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL prio_no_nesting got %b want 0", oInterrupt);
    end
    iKernelMode = 1'b0;
    tick();
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL prio_return_edge got %b want 0", oInterrupt);
    end
    tick();
    checks++;
    if (oInterrupt !== 1'b1) begin
      errors++; $display("FAIL prio_second_irq got %b want 1", oInterrupt);
    end
    busRead(CAUSE_A, rd);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++; $display("FAIL prio_cause2 got %h want %h", rd, exp);
    end
    iKernelMode = 1'b1;
    tick();
    iKernelMode = 1'b0;
    tick();
  endtask

  task automatic test_masking;
    logic [31:0] rd, exp;
    busWrite(CTRL_A, 32'h0);
    busWrite(MASK_A, 32'h0);
    iSrc = 4'h2;
    tick();
    iSrc = 4'h0;
    repeat (4) tick();
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL mask_blocked got %b want 0", oInterrupt);
    end
    busRead(PEND_A, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++; $display("FAIL mask_pend got %h want 2", rd);
    end
    busWrite(MASK_A, 32'h2);
    repeat (2) tick();
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL mask_gen_off got %b want 0", oInterrupt);
    end
    busWrite(CTRL_A, 32'h1);
    expQ.push_back(32'h8000_0001);
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL mask_gen_write_edge got %b want 0", oInterrupt);
    end
    tick();
    checks++;
    if (oInterrupt !== 1'b1) begin
      errors++; $display("FAIL mask_gen_fire got %b want 1", oInterrupt);
    end
    busRead(CAUSE_A, rd);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++; $display("FAIL mask_cause got %h want %h", rd, exp);
    end
  endtask

  task automatic test_withdraw;
    logic [31:0] rd;
    busWrite(PEND_A, 32'h2);
    checks++;
    if (oInterrupt !== 1'b1) begin
      errors++; $display("FAIL withdraw_hold got %b want 1", oInterrupt);
    end
    tick();
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL withdraw_irq got %b want 0", oInterrupt);
    end
    busRead(CAUSE_A, rd);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errors++; $display("FAIL withdraw_cause got %h want 00000001", rd);
    end
  endtask

  task automatic test_collision;
    logic [31:0] rd;
    busWrite(CTRL_A, 32'h0);
    iSrc = 4'h1;
    tick();
    iSrc = 4'h0;
    tick();
    busRead(PEND_A, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++; $display("FAIL coll_pre_pend got %h want 1", rd);
    end
    iSrc = 4'h1;
    busWrite(PEND_A, 32'h1);
    busRead(PEND_A, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++; $display("FAIL coll_set_wins got %h want 1", rd);
    end
    iSrc = 4'h0;
    busWrite(PEND_A, 32'h1);
    busRead(PEND_A, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL coll_clear got %h want 0", rd);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] rd, exp;
    int cyc;
    bit to;
    busWrite(MASK_A, 32'h1);
    busWrite(CTRL_A, 32'h1);
    iSrc = 4'h1;
    expQ.push_back(32'h8000_0000);
    waitIrq(cyc, to);
    iSrc = 4'h0;
    busRead(CAUSE_A, rd);
    exp = expQ.pop_front();
    checks++;
    if (to || rd !== exp) begin
      errors++; $display("FAIL areset_req_cause got %h timeout %0d want %h", rd, to, exp);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL areset_req_drop got %b want 0", oInterrupt);
    end
    reset = 1'b1;
    tick();
    busWrite(MASK_A, 32'h4);
    busWrite(CTRL_A, 32'h1);
    iSrc = 4'h4;
    expQ.push_back(32'h8000_0002);
    waitIrq(cyc, to);
    checks++;
    if (to || cyc != 2) begin
      errors++; $display("FAIL areset_post_latency got %0d timeout %0d want 2", cyc, to);
    end
    iSrc = 4'h0;
    busRead(CAUSE_A, rd);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++; $display("FAIL areset_post_cause got %h want %h", rd, exp);
    end
    iKernelMode = 1'b1;
    iSrc = 4'h1;
    tick();
    iSrc = 4'h0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL areset_svc_irq got %b want 0", oInterrupt);
    end
    for (int i = 0; i < 4; i++) begin
      busRead(BASE + 32'(i * 4), rd);
      checks++;
      if (rd !== 32'd0) begin
        errors++; $display("FAIL areset_svc_reg%0d got %h want 0", i, rd);
      end
    end
    reset = 1'b1;
    iKernelMode = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    iSrc        = '0;
    iKernelMode = 1'b0;
    iAddr       = '0;
    iRead       = 1'b0;
    iWrite      = 1'b0;
    iWriteData  = '0;
    test_reset();
    test_regs();
    test_basic();
    test_priority();
    test_masking();
    test_withdraw();
    test_collision();
    test_async_reset();
    checks++;
    if (expQ.size() !== 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller for the single-cycle MIPS core. It collects up to `N_SRC` peripheral interrupt lines, latches rising edges into pending bits, and applies per-source masking and a global enable. It presents one fixed-priority request to the core's `iInterrupt` input and sequences the request, acknowledge and service handshake by watching the core's kernel-mode bit (PC[31]). It sits on the core's data-memory bus beside the other peripherals.

## Interface
Parameters:
- `N_SRC`, 4: number of interrupt sources, 1..8.
- `BASE_ADDR`, 32'h40000020: byte address of the register block (16-byte aligned).

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `iSrc` in N_SRC: interrupt source lines, synchronous to `clk`, level. A rising edge raises a request.
- `iKernelMode` in 1: core PC[31]. 1 means the core is in kernel/handler mode.
- `iAddr` in 32: data-bus address (core `oMemAddr`).
- `iRead` in 1: bus read strobe.
- `iWrite` in 1: bus write strobe.
- `iWriteData` in 32: bus write data.
- `oReadData` out 32: combinational read data. It is 0 when not selected.
- `oInterrupt` out 1: interrupt request to the core's `iInterrupt`.

## Operation
Registers (offset from `BASE_ADDR`; word accesses only; `iAddr[1:0]` ignored):
- 0x0 PEND: read gives pending bits [N_SRC-1:0]. Write-1-to-clear.
- 0x4 MASK: read/write, bits [N_SRC-1:0]. 1 enables the source. Upper bits read 0.
- 0x8 CAUSE: read-only. Bit 31 = a cause is latched; bits [2:0] = source id. Writes ignored.
- 0xC CTRL: read/write. Bit 0 = global enable (GEN). Other bits read 0.
- Any other address inside the 16-byte window reads 0 and ignores writes. Addresses outside the window are not selected.

Edge capture:
- `src_d` holds `iSrc` delayed by one cycle.
- `rise = iSrc & ~src_d`. On each edge, `PEND |= rise`.
- Set takes precedence over a same-cycle W1C clear and over a same-cycle hardware acknowledge clear.

Arbitration:
- `active = PEND & MASK`, qualified by GEN.
- Fixed priority: the lowest set index of `active` wins.

State machine:
- IDLE -> REQ when GEN=1, `active`≠0 and `iKernelMode`=0. On this transition CAUSE is latched as {1, winner id}.
- REQ -> SERVICE when `iKernelMode`=1 (handler entered). The latched source's PEND bit is cleared (hardware acknowledge).
- REQ -> IDLE when the latched source is no longer in `active` (cleared, masked, or GEN dropped) before kernel entry. CAUSE bit 31 is cleared (request withdrawn).
- SERVICE -> IDLE when `iKernelMode`=0 (handler returned). CAUSE keeps its value until the next IDLE -> REQ transition.
- In REQ, CAUSE stays fixed even if a higher-priority source becomes pending.

Output:
- `oInterrupt = (state == REQ)`, driven from a registered state bit with no combinational path from inputs.

Reset (while `reset`=0, asynchronous):
- state = IDLE; `oInterrupt` = 0.
- PEND, MASK, CTRL, CAUSE and `src_d` = 0.

## Timing
- Source rise sampled at edge k sets PEND at edge k.
- IDLE -> REQ happens at edge k+1, so `oInterrupt` is high during cycle k+1. Minimum latency is 2 edges from the first cycle `iSrc` is high.
- Kernel entry (`iKernelMode`=1) sampled at an edge moves the state to SERVICE. `oInterrupt` drops in the following cycle.
- A register write takes effect at the edge ending the write cycle.
- Register reads are combinational in the same cycle (required by the single-cycle core).
- No nesting: new pending sources wait in PEND until SERVICE -> IDLE, then fire one edge later.
- `reset` asserted mid-handshake returns to IDLE immediately and drops `oInterrupt` asynchronously.

## Test plan
- Reset: hold `reset`=0 with `iSrc`=4'hF -> `oInterrupt`=0 and all registers read 0. After release, PEND reads 0 until the next rising edge.
- Basic flow: MASK=4'h4, CTRL=1, pulse `iSrc`[2] -> `oInterrupt`=1 two edges later and CAUSE=32'h80000002. Raise `iKernelMode` -> `oInterrupt`=0 and PEND[2]=0. Lower `iKernelMode` -> state IDLE.
- Priority and no nesting: MASK=4'hF, CTRL=1, raise `iSrc`[3] and `iSrc`[1] together -> CAUSE id=1. During SERVICE, PEND=4'h8. After return, a second request fires with CAUSE id=3.
- Masking and enable: pending source with MASK=0 -> `oInterrupt` never rises. Setting MASK bit with CTRL=0 -> still 0. Setting CTRL=1 -> request fires on the next edge.
- Withdraw and collision: in REQ, W1C the latched bit -> return to IDLE and CAUSE[31]=0. In the same cycle as a W1C to PEND[0], a new `iSrc`[0] rise -> PEND[0] stays 1.
- Async reset in SERVICE -> state IDLE and `oInterrupt`=0 without a clock edge.
